// File: rtl/sb_tx_arbiter_if.sv
// Sideband TX arbitration bundle: per-requester message inputs, acks, and the shared SB TX channel.
// The master modport is the arbiter's view; the slave modport is the requesters plus SB TX.
`timescale 1ns/1ps
interface sb_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 64,
    parameter int MSG_W  = 8
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]             req_valid_i;
    logic [N_REQ-1:0][MSG_W-1:0]  req_msg_i;
    logic [N_REQ-1:0][DATA_W-1:0] req_data_i;
    logic [N_REQ-1:0]             req_ack_o;
    logic [N_REQ-1:0]             grant_o;
    logic [MSG_W-1:0]             SB_TX_msg_o;
    logic [DATA_W-1:0]            SB_TX_dataBus_o;
    logic                         SB_TX_msg_valid_o;
    logic                         SB_TX_msg_sendNextFlag_i;
    logic                         timeout_o;
    logic [IDX_W-1:0]             timeout_id_o;

    modport master (
        input  req_valid_i, req_msg_i, req_data_i, SB_TX_msg_sendNextFlag_i,
        output req_ack_o, grant_o, SB_TX_msg_o, SB_TX_dataBus_o, SB_TX_msg_valid_o,
               timeout_o, timeout_id_o
    );

    modport slave (
        output req_valid_i, req_msg_i, req_data_i, SB_TX_msg_sendNextFlag_i,
        input  req_ack_o, grant_o, SB_TX_msg_o, SB_TX_dataBus_o, SB_TX_msg_valid_o,
               timeout_o, timeout_id_o
    );
endinterface

// File: rtl/sb_tx_arbiter.sv
// Round-robin owner of the single sideband TX channel shared by the LTSM substate blocks.
// One message in flight at a time; released by sendNextFlag (acked) or by timeout (not acked).
`timescale 1ns/1ps
module sb_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 64,
    parameter int MSG_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            clk_100MHz,
    input  logic            reset_n,
    input  logic            enable_i,
    sb_tx_arbiter_if.master sb_if
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_timeout_id;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_REQ-1:0]  r_grant;
    logic [N_REQ-1:0]  r_ack;
    logic [MSG_W-1:0]  r_msg;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_timeout;

    logic              w_any;
    logic [IDX_W-1:0]  w_win;
    logic [IDX_W-1:0]  w_scan;
    logic              w_do_grant;
    logic              w_do_ack;
    logic              w_do_tmo;

    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(N_REQ - 1)) return '0;
        return idx + IDX_W'(1);
    endfunction

    function automatic logic [N_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scan requesters starting at the round-robin pointer, wrapping at N_REQ.
    always_comb begin
        w_any  = 1'b0;
        w_win  = r_ptr;
        w_scan = r_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_any && sb_if.req_valid_i[w_scan]) begin
                w_any = 1'b1;
                w_win = w_scan;
            end
            w_scan = f_next(w_scan);
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // sendNextFlag is checked before the timeout so a flag on the last cycle still acks.
    always_comb begin
        w_state_nxt = r_state;
        w_do_grant  = 1'b0;
        w_do_ack    = 1'b0;
        w_do_tmo    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_i && w_any) begin
                    w_do_grant  = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sb_if.SB_TX_msg_sendNextFlag_i) begin
                    w_do_ack    = 1'b1;
                    w_state_nxt = ST_GAP;
                end else if (r_cnt == CNT_LAST) begin
                    w_do_tmo    = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr        <= '0;
            r_owner      <= '0;
            r_timeout_id <= '0;
            r_cnt        <= '0;
            r_grant      <= '0;
            r_ack        <= '0;
            r_msg        <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_timeout <= 1'b0;
            if (w_do_grant) begin
                r_owner <= w_win;
                r_grant <= f_onehot(w_win);
                r_valid <= 1'b1;
                r_msg   <= sb_if.req_msg_i[w_win];
                r_data  <= sb_if.req_data_i[w_win];
            end
            if (w_do_ack || w_do_tmo) begin
                r_valid <= 1'b0;
                r_grant <= '0;
                r_ptr   <= f_next(r_owner);
            end
            if (w_do_ack) r_ack <= f_onehot(r_owner);
            if (w_do_tmo) begin
                r_timeout    <= 1'b1;
                r_timeout_id <= r_owner;
            end
            // Counter only runs while a message is waiting; any release clears it.
            if (r_state == ST_WAIT && !w_do_ack && !w_do_tmo) r_cnt <= r_cnt + CNT_W'(1);
            else                                              r_cnt <= '0;
        end
    end

    assign sb_if.req_ack_o         = r_ack;
    assign sb_if.grant_o           = r_grant;
    assign sb_if.SB_TX_msg_o       = r_msg;
    assign sb_if.SB_TX_dataBus_o   = r_data;
    assign sb_if.SB_TX_msg_valid_o = r_valid;
    assign sb_if.timeout_o         = r_timeout;
    assign sb_if.timeout_id_o      = r_timeout_id;
endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter: stimulus pushes expected channel events into a queue,
// a negedge monitor pops and compares each message start, ack pulse and timeout pulse.
`timescale 1ns/1ps
module tb_sb_tx_arbiter;
    localparam int N_REQ       = 4;
    localparam int DATA_W      = 64;
    localparam int MSG_W       = 8;
    localparam int TIMEOUT_CYC = 8;
    localparam logic [MSG_W-1:0] MBTRAIN_REQ = 8'h35;
    localparam int K_MSG = 0;
    localparam int K_ACK = 1;
    localparam int K_TMO = 2;

    typedef struct {
        int                kind;
        int                cyc;
        logic [N_REQ-1:0]  vec;
        logic [MSG_W-1:0]  msg;
        logic [DATA_W-1:0] data;
    } ev_t;

    logic clk_100MHz = 1'b0;
    logic reset_n    = 1'b0;
    logic enable_i   = 1'b0;
    int   cyc        = 0;
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   c;
    ev_t  exp_q[$];
    ev_t  cur;
    logic prev_valid = 1'b0;
    logic [N_REQ-1:0] one = 1;

    sb_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MSG_W(MSG_W)) sb_if ();

    sb_tx_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .MSG_W(MSG_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset_n   (reset_n),
        .enable_i  (enable_i),
        .sb_if     (sb_if)
    );

    always #5 clk_100MHz = ~clk_100MHz;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    function automatic logic [MSG_W-1:0] f_msg(input int i);
        return MSG_W'(8'h10 + i);
    endfunction

    function automatic logic [DATA_W-1:0] f_data(input int i);
        return 64'hA5A5_0000_0000_0000 + DATA_W'(i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input int at, input logic [N_REQ-1:0] vec,
                        input logic [MSG_W-1:0] msg, input logic [DATA_W-1:0] data);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.vec  = vec;
        e.msg  = msg;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [N_REQ-1:0] vec,
                           input logic [MSG_W-1:0] msg, input logic [DATA_W-1:0] data);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event kind=%0d cycle=%0d vec=%b msg=%h data=%h required=none",
                     kind, cyc, vec, msg, data);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.vec !== vec ||
            (kind == K_MSG && (e.msg !== msg || e.data !== data))) begin
            n_fail++;
            $display("FAIL event actual kind=%0d cyc=%0d vec=%b msg=%h data=%h required kind=%0d cyc=%0d vec=%b msg=%h data=%h",
                     kind, cyc, vec, msg, data, e.kind, e.cyc, e.vec, e.msg, e.data);
        end
        if (kind == K_MSG) cur = e;
    endtask

    always @(negedge clk_100MHz) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            check("grant_eq_valid", 64'(|sb_if.grant_o), 64'(sb_if.SB_TX_msg_valid_o));
            if (sb_if.SB_TX_msg_valid_o && !prev_valid) begin
                observe(K_MSG, sb_if.grant_o, sb_if.SB_TX_msg_o, sb_if.SB_TX_dataBus_o);
            end else if (sb_if.SB_TX_msg_valid_o) begin
                check("hold_grant", 64'(sb_if.grant_o), 64'(cur.vec));
                check("hold_msg", 64'(sb_if.SB_TX_msg_o), 64'(cur.msg));
                check("hold_data", sb_if.SB_TX_dataBus_o, cur.data);
            end
            if (|sb_if.req_ack_o) observe(K_ACK, sb_if.req_ack_o, '0, '0);
            if (sb_if.timeout_o) observe(K_TMO, N_REQ'(sb_if.timeout_id_o), '0, '0);
            prev_valid = sb_if.SB_TX_msg_valid_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(sb_if.SB_TX_msg_valid_o), 64'd0);
        check({tag, "_grant"}, 64'(sb_if.grant_o), 64'd0);
        check({tag, "_ack"}, 64'(sb_if.req_ack_o), 64'd0);
        check({tag, "_msg"}, 64'(sb_if.SB_TX_msg_o), 64'd0);
        check({tag, "_data"}, sb_if.SB_TX_dataBus_o, 64'd0);
        check({tag, "_timeout"}, 64'(sb_if.timeout_o), 64'd0);
        check({tag, "_timeout_id"}, 64'(sb_if.timeout_id_o), 64'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        sb_if.req_valid_i              = '0;
        sb_if.req_msg_i                = '0;
        sb_if.req_data_i               = '0;
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b0;
        tick(3);
        check_all_zero("reset_init");
        reset_n = 1'b1;
        tick(2);

        // Fairness: everyone pending, SB TX always ready -> 0,1,2,3,0,... every 3 cycles.
        c = cyc;
        for (int i = 0; i < N_REQ; i++) begin
            sb_if.req_msg_i[i]  = f_msg(i);
            sb_if.req_data_i[i] = f_data(i);
        end
        enable_i                       = 1'b1;
        sb_if.req_valid_i              = 4'b1111;
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b1;
        for (int j = 0; j < 8; j++) begin
            push(K_MSG, c + 1 + 3 * j, one << (j % 4), f_msg(j % 4), f_data(j % 4));
            push(K_ACK, c + 2 + 3 * j, one << (j % 4), '0, '0);
        end
        tick(24);
        sb_if.req_valid_i              = '0;
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b0;
        tick(3);

        // Single request held 4 cycles; owner's inputs change mid-WAIT and must be ignored.
        c = cyc;
        sb_if.req_valid_i   = 4'b0100;
        sb_if.req_msg_i[2]  = MBTRAIN_REQ;
        sb_if.req_data_i[2] = 64'hDEAD_BEEF;
        push(K_MSG, c + 1, 4'b0100, MBTRAIN_REQ, 64'hDEAD_BEEF);
        tick(1);
        sb_if.req_msg_i[2]  = 8'hFF;
        sb_if.req_data_i[2] = '1;
        tick(3);
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b1;
        push(K_ACK, c + 5, 4'b0100, '0, '0);
        tick(1);
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b0;
        sb_if.req_valid_i              = '0;
        tick(3);

        // enable_i low blocks grants (flag in IDLE ignored); low during WAIT does not.
        c = cyc;
        enable_i                       = 1'b0;
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b1;
        sb_if.req_valid_i              = 4'b0011;
        sb_if.req_msg_i[0]             = 8'h21;
        sb_if.req_data_i[0]            = 64'h0123_4567_89AB_CDEF;
        sb_if.req_msg_i[1]             = 8'h22;
        sb_if.req_data_i[1]            = 64'hFEDC_BA98_7654_3210;
        tick(5);
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b0;
        enable_i                       = 1'b1;
        push(K_MSG, c + 6, 4'b0001, 8'h21, 64'h0123_4567_89AB_CDEF);
        tick(1);
        enable_i          = 1'b0;
        sb_if.req_valid_i = 4'b0010;
        push(K_ACK, c + 8, 4'b0001, '0, '0);
        tick(1);
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b1;
        tick(1);
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b0;
        enable_i                       = 1'b1;
        push(K_MSG, c + 10, 4'b0010, 8'h22, 64'hFEDC_BA98_7654_3210);
        tick(2);
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b1;
        push(K_ACK, c + 11, 4'b0010, '0, '0);
        tick(1);
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b0;
        sb_if.req_valid_i              = '0;
        tick(3);

        // Timeout after 8 valid cycles, re-grant 2 later, then flag on the timeout cycle acks.
        c = cyc;
        sb_if.req_valid_i   = 4'b0010;
        sb_if.req_msg_i[1]  = 8'h33;
        sb_if.req_data_i[1] = 64'h0000_0000_CAFE_F00D;
        push(K_MSG, c + 1, 4'b0010, 8'h33, 64'h0000_0000_CAFE_F00D);
        push(K_TMO, c + 9, 4'b0001, '0, '0);
        push(K_MSG, c + 11, 4'b0010, 8'h33, 64'h0000_0000_CAFE_F00D);
        tick(18);
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b1;
        push(K_ACK, c + 19, 4'b0010, '0, '0);
        tick(1);
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b0;
        sb_if.req_valid_i              = '0;
        tick(2);
        check("timeout_id_held", 64'(sb_if.timeout_id_o), 64'd1);

        // Reset mid-WAIT clears everything at once; pointer restarts at 0.
        c = cyc;
        sb_if.req_valid_i   = 4'b1110;
        sb_if.req_msg_i[2]  = 8'h44;
        sb_if.req_data_i[2] = 64'h4444_4444;
        sb_if.req_msg_i[3]  = 8'h55;
        sb_if.req_data_i[3] = 64'h5555_5555;
        push(K_MSG, c + 1, 4'b0100, 8'h44, 64'h4444_4444);
        tick(2);
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_midwait");
        tick(1);
        reset_n = 1'b1;
        c = cyc;
        push(K_MSG, c + 1, 4'b0010, 8'h33, 64'h0000_0000_CAFE_F00D);
        tick(1);
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b1;
        push(K_ACK, c + 2, 4'b0010, '0, '0);
        tick(1);
        sb_if.SB_TX_msg_sendNextFlag_i = 1'b0;
        sb_if.req_valid_i              = '0;
        tick(4);

        check("events_outstanding", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
